waterfall_fb_ctrl: RTL and testbench

- Sole owner of the frame-buffer SPRAM port in the waterfall display.
- Sequences three activities onto that single-ported RAM: post-reset clear, per-pixel video reads with circular-scroll addressing, and line writes copied from the frequency-bin BRAM during lower blanking.
- Maintains the scroll offset and decides when a new spectrum line is committed.
- Sits between the video timing block, the dual-port freq-bin BRAM and the SPRAM frame buffer, all on the pixel clock.

---
 rtl/waterfall_pkg.sv | 17 +
 rtl/fb_row_addr.sv | 50 +++++
 rtl/waterfall_fb_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_waterfall_fb_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/waterfall_pkg.sv
// Shared definitions for the waterfall display: controller state encoding and
// default raster/bin geometry used by the video, sdft and frame-buffer blocks.
package waterfall_pkg;

  typedef enum logic [1:0] {
    CLEAR      = 2'd0,
    VIDEO      = 2'd1,
    WRITE      = 2'd2,
    WAIT_BLANK = 2'd3
  } fb_state_e;

  localparam int H_VISIBLE_DEF  = 320;
  localparam int V_VISIBLE_DEF  = 240;
  localparam int LIMIT_BINS_DEF = 320;
  localparam int SCROLL_DIV_DEF = 2;

endpackage

// File: rtl/fb_row_addr.sv
// Registered frame-buffer address: ((row + offset) mod V_VISIBLE) * H_VISIBLE + col,
// with a load path so the clear sweep can drive the same address register.
module fb_row_addr
  import waterfall_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int FB_ADDR_W = 17
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic [8:0]           col_i,
  input  logic [7:0]           row_i,
  input  logic [7:0]           offset_i,
  input  logic                 load_i,
  input  logic [FB_ADDR_W-1:0] load_addr_i,
  output logic [FB_ADDR_W-1:0] addr_o
);

  logic [8:0]           row_sum;
  logic [7:0]           row_wrapped;
  logic [FB_ADDR_W-1:0] row_ext;
  logic [FB_ADDR_W-1:0] row_base;
  logic [FB_ADDR_W-1:0] addr_d;
  logic [FB_ADDR_W-1:0] addr_q;

  // Both operands are below V_VISIBLE, so one conditional subtract is a full modulo.
  always_comb begin
    row_sum     = {1'b0, row_i} + {1'b0, offset_i};
    row_wrapped = (row_sum >= 9'(V_VISIBLE)) ? 8'(row_sum - 9'(V_VISIBLE)) : row_sum[7:0];
    row_ext     = FB_ADDR_W'(row_wrapped);
    if (H_VISIBLE == 320) begin
      row_base = (row_ext << 8) + (row_ext << 6);
    end else begin
      row_base = row_ext * FB_ADDR_W'(H_VISIBLE);
    end
    addr_d = load_i ? load_addr_i : row_base + FB_ADDR_W'(col_i);
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/waterfall_fb_ctrl.sv
// Frame-buffer SPRAM arbiter: post-reset clear, scrolled video reads, and
// spectrum line copies from the freq-bin BRAM during lower blanking.
module waterfall_fb_ctrl
  import waterfall_pkg::*;
#(
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int LIMIT_BINS = LIMIT_BINS_DEF,
  parameter int SCROLL_DIV = SCROLL_DIV_DEF,
  parameter int FB_ADDR_W  = 17,
  parameter int BIN_ADDR_W = 9,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8:0]            x,
  input  logic [7:0]            y,
  input  logic                  lower_blank,
  input  logic                  clear_req,
  output logic [BIN_ADDR_W-1:0] bin_addr,
  output logic                  bin_ren,
  input  logic [DATA_W-1:0]     bin_rdata,
  output logic [FB_ADDR_W-1:0]  fb_addr,
  output logic [DATA_W-1:0]     fb_wdata,
  output logic                  fb_wen,
  output logic [7:0]            y_offset,
  output logic                  clear_done
);

  localparam logic [FB_ADDR_W-1:0] CLR_END     = FB_ADDR_W'(H_VISIBLE * V_VISIBLE);
  localparam logic [FB_ADDR_W-1:0] WR_END      = FB_ADDR_W'(LIMIT_BINS);
  localparam logic [FB_ADDR_W-1:0] RD_LAST     = FB_ADDR_W'(LIMIT_BINS - 1);
  localparam logic [3:0]           SCROLL_LAST = 4'(SCROLL_DIV - 1);
  localparam logic [7:0]           V_LAST      = 8'(V_VISIBLE - 1);

  fb_state_e             state_q;
  logic [FB_ADDR_W-1:0]  cnt_q;
  logic [3:0]            scroll_q;
  logic [7:0]            y_offset_q;
  logic [7:0]            y_offset_d;
  logic                  clear_done_q;
  logic                  clear_pending_q;
  logic                  fb_wen_q;
  logic [DATA_W-1:0]     fb_wdata_q;
  logic [BIN_ADDR_W-1:0] bin_addr_q;
  logic                  bin_ren_q;

  logic [8:0]            col_sel;
  logic [7:0]            row_sel;
  logic                  addr_load;

  assign y_offset_d = (y_offset_q == V_LAST) ? 8'd0 : y_offset_q + 8'd1;

  // During WRITE the video row is forced to 0 so the shared path yields y_offset*H + (k-1).
  always_comb begin
    col_sel   = x;
    row_sel   = y;
    addr_load = (state_q == CLEAR);
    if (state_q == WRITE) begin
      col_sel = 9'(cnt_q - 1'b1);
      row_sel = 8'd0;
    end
  end

  fb_row_addr #(
    .H_VISIBLE (H_VISIBLE),
    .V_VISIBLE (V_VISIBLE),
    .FB_ADDR_W (FB_ADDR_W)
  ) u_row_addr (
    .clk         (clk),
    .rst_i       (reset),
    .col_i       (col_sel),
    .row_i       (row_sel),
    .offset_i    (y_offset_q),
    .load_i      (addr_load),
    .load_addr_i (cnt_q),
    .addr_o      (fb_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= CLEAR;
      cnt_q           <= '0;
      scroll_q        <= '0;
      y_offset_q      <= '0;
      clear_done_q    <= 1'b0;
      clear_pending_q <= 1'b0;
      fb_wen_q        <= 1'b0;
      fb_wdata_q      <= '0;
      bin_addr_q      <= '0;
      bin_ren_q       <= 1'b0;
    end else begin
      fb_wen_q   <= 1'b0;
      fb_wdata_q <= '0;
      case (state_q)
        CLEAR: begin
          if (cnt_q == CLR_END) begin
            clear_done_q <= 1'b1;
            y_offset_q   <= '0;
            scroll_q     <= '0;
            cnt_q        <= '0;
            state_q      <= VIDEO;
          end else begin
            fb_wen_q     <= 1'b1;
            clear_done_q <= 1'b0;
            cnt_q        <= cnt_q + 1'b1;
          end
        end

        VIDEO: begin
          if (clear_req) begin
            clear_done_q <= 1'b0;
            cnt_q        <= '0;
            state_q      <= CLEAR;
          end else if (lower_blank) begin
            if (scroll_q == SCROLL_LAST) begin
              scroll_q   <= '0;
              cnt_q      <= '0;
              bin_addr_q <= '0;
              bin_ren_q  <= 1'b1;
              state_q    <= WRITE;
            end else begin
              scroll_q <= scroll_q + 4'd1;
              state_q  <= WAIT_BLANK;
            end
          end
        end

        // Bin k is requested in cycle k, its data lands in cycle k+1 and is written then.
        WRITE: begin
          if (clear_req) begin
            clear_pending_q <= 1'b1;
          end
          if (cnt_q != '0) begin
            fb_wen_q   <= 1'b1;
            fb_wdata_q <= bin_rdata;
          end
          if (cnt_q < RD_LAST) begin
            bin_addr_q <= BIN_ADDR_W'(cnt_q + 1'b1);
            bin_ren_q  <= 1'b1;
          end else begin
            bin_ren_q <= 1'b0;
          end
          if (cnt_q == WR_END) begin
            y_offset_q <= y_offset_d;
            cnt_q      <= '0;
            if (clear_pending_q || clear_req) begin
              clear_pending_q <= 1'b0;
              state_q         <= CLEAR;
            end else begin
              state_q <= WAIT_BLANK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        WAIT_BLANK: begin
          if (clear_req) begin
            clear_done_q <= 1'b0;
            cnt_q        <= '0;
            state_q      <= CLEAR;
          end else if (!lower_blank) begin
            state_q <= VIDEO;
          end
        end

        default: state_q <= CLEAR;
      endcase
    end
  end

  assign fb_wen     = fb_wen_q;
  assign fb_wdata   = fb_wdata_q;
  assign bin_addr   = bin_addr_q;
  assign bin_ren    = bin_ren_q;
  assign y_offset   = y_offset_q;
  assign clear_done = clear_done_q;

endmodule

// File: tb/tb_waterfall_fb_ctrl.sv
// Directed bench for waterfall_fb_ctrl with a short frame (16 rows) so every
// clear completes quickly; BRAM model returns its own address as data.
module tb_waterfall_fb_ctrl;

  localparam int H  = 320;
  localparam int V  = 16;
  localparam int L  = 320;
  localparam int SD = 2;
  localparam int N  = H * V;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  x = '0;
  logic [7:0]  y = '0;
  logic        lower_blank = 1'b0;
  logic        clear_req = 1'b0;
  logic [8:0]  bin_addr;
  logic        bin_ren;
  logic [7:0]  bin_rdata = '0;
  logic [16:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        fb_wen;
  logic [7:0]  y_offset;
  logic        clear_done;

  int checks = 0;
  int errors = 0;
  int model_off = 0;

  waterfall_fb_ctrl #(
    .H_VISIBLE (H), .V_VISIBLE (V), .LIMIT_BINS (L), .SCROLL_DIV (SD),
    .FB_ADDR_W (17), .BIN_ADDR_W (9), .DATA_W (8)
  ) dut (
    .clk (clk), .reset (reset), .x (x), .y (y),
    .lower_blank (lower_blank), .clear_req (clear_req),
    .bin_addr (bin_addr), .bin_ren (bin_ren), .bin_rdata (bin_rdata),
    .fb_addr (fb_addr), .fb_wdata (fb_wdata), .fb_wen (fb_wen),
    .y_offset (y_offset), .clear_done (clear_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bin_ren) bin_rdata <= bin_addr[7:0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if (fb_wen !== 1'b0 || fb_addr !== 17'd0 || fb_wdata !== 8'd0) begin
      errors++;
      $display("FAIL reset_fb: wen=%0b addr=%0d wdata=%0d expected 0/0/0", fb_wen, fb_addr, fb_wdata);
    end
    checks++;
    if (bin_ren !== 1'b0 || bin_addr !== 9'd0 || y_offset !== 8'd0 || clear_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: ren=%0b baddr=%0d yoff=%0d done=%0b expected all 0", bin_ren, bin_addr, y_offset, clear_done);
    end
    reset = 1'b0;
  endtask

  task automatic test_clear_sweep();
    int bad = 0;
    int first_bad = -1;
    for (int i = 0; i < N; i++) begin
      tick();
      if (fb_wen !== 1'b1 || fb_addr !== 17'(i) || fb_wdata !== 8'd0 || clear_done !== 1'b0) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_sweep: %0d bad cycles (first at %0d) expected 0", bad, first_bad);
    end
    tick();
    checks++;
    if (fb_wen !== 1'b0 || clear_done !== 1'b1 || y_offset !== 8'd0) begin
      errors++;
      $display("FAIL clear_end: wen=%0b done=%0b yoff=%0d expected 0/1/0", fb_wen, clear_done, y_offset);
    end
  endtask

  task automatic video_check(input int xi, input int yi, input int exp_addr);
    x = 9'(xi);
    y = 8'(yi);
    tick();
    checks++;
    if (fb_addr !== 17'(exp_addr) || fb_wen !== 1'b0) begin
      errors++;
      $display("FAIL video_addr x=%0d y=%0d: addr=%0d wen=%0b expected %0d/0", xi, yi, fb_addr, fb_wen, exp_addr);
    end
  endtask

  task automatic test_video_addr();
    video_check(5, 3, 965);
    video_check(319, 15, 5119);
    x = '0;
    y = '0;
  endtask

  task automatic blank_no_write();
    int wcnt = 0;
    lower_blank = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (fb_wen === 1'b1) wcnt++;
      if (i == 2) lower_blank = 1'b0;
    end
    checks++;
    if (wcnt != 0) begin
      errors++;
      $display("FAIL blank_no_write: saw %0d writes expected 0", wcnt);
    end
  endtask

  // Drives one write-producing blank; stops at the first cycle after the line burst.
  task automatic blank_write(input int clear_at);
    int wcnt = 0;
    int bad = 0;
    bit done = 0;
    int base = model_off * H;
    lower_blank = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      clear_req = 1'b0;
      if (i == 2) lower_blank = 1'b0;
      if (fb_wen === 1'b1 && clear_done === 1'b1) begin
        if (fb_addr !== 17'(base + wcnt) || fb_wdata !== 8'(wcnt)) bad++;
        wcnt++;
        if (wcnt == clear_at) clear_req = 1'b1;
      end else if (wcnt > 0) begin
        done = 1;
      end
    end
    clear_req = 1'b0;
    checks++;
    if (!done || wcnt != L) begin
      errors++;
      $display("FAIL line_write_count base=%0d: writes=%0d ended=%0b expected %0d/1", base, wcnt, done, L);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL line_write_data base=%0d: %0d bad writes expected 0", base, bad);
    end
    model_off = (model_off == V - 1) ? 0 : model_off + 1;
    checks++;
    if (y_offset !== 8'(model_off) || bin_ren !== 1'b0) begin
      errors++;
      $display("FAIL y_offset_step: yoff=%0d ren=%0b expected %0d/0", y_offset, bin_ren, model_off);
    end
  endtask

  task automatic test_scroll_write();
    blank_no_write();
    blank_write(-1);
  endtask

  task automatic test_offset_wrap();
    for (int c = 0; c < V; c++) begin
      if (model_off == V - 1) begin
        video_check(0, 1, 0);
        video_check(7, 14, 4167);
        x = '0;
        y = '0;
      end
      blank_no_write();
      blank_write(-1);
    end
  endtask

  task automatic test_clear_during_write();
    int cnt = 1;
    int bad = 0;
    blank_no_write();
    blank_write(100);
    checks++;
    if (fb_wen !== 1'b1 || fb_addr !== 17'd0 || clear_done !== 1'b0) begin
      errors++;
      $display("FAIL clear_after_write_start: wen=%0b addr=%0d done=%0b expected 1/0/0", fb_wen, fb_addr, clear_done);
    end
    for (int i = 0; i < N + 20; i++) begin
      tick();
      if (clear_done === 1'b1) break;
      if (fb_wen !== 1'b1 || fb_addr !== 17'(cnt)) bad++;
      cnt++;
    end
    checks++;
    if (cnt != N || bad != 0 || clear_done !== 1'b1) begin
      errors++;
      $display("FAIL clear_after_write: writes=%0d bad=%0d done=%0b expected %0d/0/1", cnt, bad, clear_done, N);
    end
    model_off = 0;
    checks++;
    if (y_offset !== 8'd0) begin
      errors++;
      $display("FAIL clear_after_write_yoff: yoff=%0d expected 0", y_offset);
    end
  endtask

  task automatic test_reset_mid_clear();
    bit found = 0;
    int bad = 0;
    blank_no_write();
    blank_write(-1);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    checks++;
    if (clear_done !== 1'b0) begin
      errors++;
      $display("FAIL clear_req_drop: done=%0b expected 0", clear_done);
    end
    for (int i = 0; i < N + 10 && !found; i++) begin
      tick();
      if (fb_wen === 1'b1 && fb_addr === 17'd5000) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_addr_5000: timeout, addr=%0d expected 5000", fb_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (fb_wen !== 1'b0 || fb_addr !== 17'd0 || y_offset !== 8'd0 || clear_done !== 1'b0 || bin_ren !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: wen=%0b addr=%0d yoff=%0d done=%0b ren=%0b expected 0", fb_wen, fb_addr, y_offset, clear_done, bin_ren);
    end
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fb_wen !== 1'b1 || fb_addr !== 17'(i)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_restart: %0d bad cycles expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_clear_sweep();
    test_video_addr();
    test_scroll_write();
    test_offset_wrap();
    test_clear_during_write();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
